rsa_mont_engine: RTL
====================

# rsa_mont_engine

Modular-arithmetic responder for the RSA-256 datapath. Serves the two request types the exponentiation core issues: Montgomery transform (`a·2^256 mod n`) and Montgomery product (`a·b·2^-256 mod n`). Each request is a one-cycle start pulse; the engine returns a one-cycle done pulse with a registered 256-bit result. It is a bit-serial engine, one iteration per clock, serving one request at a time.

## Interface
- No parameters (operand width fixed at 256).
- `i_clk` input 1: clock, rising edge.
- `i_rst` input 1: reset, asynchronous, active-high.
- `i_n` input 256: modulus. Must be odd and greater than 2. Latched at request acceptance.
- `i_start_trans` input 1: transform request pulse.
- `i_start_mul` input 1: Montgomery-product request pulse.
- `i_op1` input 256: operand a, which must be less than n. Latched at acceptance.
- `i_op2` input 256: operand b (product only), which must be less than n. Latched at acceptance.
- `o_trans_done` output 1: one-cycle pulse; `o_transreturn` valid.
- `o_mul_done` output 1: one-cycle pulse; `o_mulreturn` valid.
- `o_transreturn` output 256: transform result.
- `o_mulreturn` output 256: product result.
- `o_busy` output 1: high in S_TRANS, S_MONT and S_FINAL.

## Operation
- States:
  - S_IDLE
  - S_TRANS (256 cycles)
  - S_MONT (256 cycles)
  - S_FINAL (1 cycle, product only)
  - S_DONE (1 cycle)
- Acceptance:
  - A start is accepted only in S_IDLE or S_DONE.
  - Starts in any other state are ignored; they are not queued.
  - Acceptance in S_DONE is required: the core re-requests combinationally in the same cycle it sees done.
  - If `i_start_trans` and `i_start_mul` are both high, transform wins and the product request is dropped.
- Accepting a request latches `i_n`, `i_op1`, `i_op2` into internal registers and clears the 8-bit iteration counter.
- Transform (S_TRANS):
  - Initialise `t = a`, held in 257 bits.
  - Each cycle: `t2 = 2t`; `t = (t2 ≥ n) ? t2 − n : t2`.
  - Invariant: `t < n`, so one subtraction per step is sufficient.
  - After 256 iterations, go to S_DONE and latch `o_transreturn = t[255:0]`.
- Product (S_MONT):
  - Initialise `m = 0`, held in 258 bits.
  - Iteration i: if `b[i]`, `m += a`; then if m is odd, `m += n`; then `m >>= 1`.
  - Invariant: `m < 2n` (intermediates stay below `4n < 2^258`).
- S_FINAL: `m = (m ≥ n) ? m − n : m`; latch `o_mulreturn`; go to S_DONE.
- S_DONE:
  - Assert the matching done output for exactly one cycle.
  - Go to S_IDLE, or directly to S_TRANS/S_MONT if a start is accepted in this cycle.
- Result registers hold their value until the next completion of the same operation type. A product does not disturb `o_transreturn`, and vice versa.
- Preconditions: operands below n and n odd. Violations produce an unspecified result but must not hang the FSM; latency is unchanged.

## Timing
- Reset (asynchronous, any state):
  - state goes to S_IDLE;
  - all outputs go to 0 (both dones, both returns, busy);
  - counter and working registers are cleared.
  - Reset mid-operation aborts the operation; no done pulse follows.
- Let edge E be the edge sampling an accepted start.
  - Transform: `o_trans_done` is high in the cycle after edge E+256 (257 cycles after acceptance).
  - Product: `o_mul_done` is high in the cycle after edge E+257 (258 cycles after acceptance).
- A done pulse and the result update become visible at the same edge. The result is stable for the entire done cycle and afterwards.
- Back-to-back: a start accepted in the S_DONE cycle begins iterating at the next edge. Throughput is one transform per 257 cycles or one product per 258 cycles.
- `o_busy` is low in S_IDLE and S_DONE.
- Done outputs never assert without a preceding accepted start.

## Test plan
- **Transform.** n=13, op1=5, one-cycle `i_start_trans` → `o_trans_done` pulses once, 257 cycles after acceptance, with `o_transreturn` = 2.
- **Product.** n=13, op1=2, op2=2, `i_start_mul` → `o_mul_done` 258 cycles after acceptance, with `o_mulreturn` = 10. With op2=1 → 5. With op1=0 → 0.
- **Chained product.** Assert `i_start_mul` (op1=2, op2=1) in the same cycle `o_mul_done` is high → first result 10 is held through the done cycle; second result 5 arrives 258 cycles later; no idle gap.
- **Request arbitration.**
  - `i_start_trans` and `i_start_mul` high together → only `o_trans_done` fires.
  - Starts pulsed mid-operation are ignored: no extra done, result unchanged.
  - `o_transreturn` is unchanged after a product completes.
- **Reset mid-operation.** Assert `i_rst` 100 cycles into a product → all outputs 0 immediately, no done afterwards. A fresh transform after release completes normally.
- **Full-width sweep.** Random 256-bit odd n with `n > 2^255`, random `a, b < n` → results match a reference model computing `a·2^256 mod n` and `a·b·2^-256 mod n`, including a = n−1.

Source files
------------

// File: rtl/rsa_mont_engine.sv
// rtl/rsa_mont_engine.sv - bit-serial RSA-256 Montgomery transform / product engine

module rsa_mont_engine (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [255:0] i_n,
    input  logic         i_start_trans,
    input  logic         i_start_mul,
    input  logic [255:0] i_op1,
    input  logic [255:0] i_op2,
    output logic         o_trans_done,
    output logic         o_mul_done,
    output logic [255:0] o_transreturn,
    output logic [255:0] o_mulreturn,
    output logic         o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRANS,
        S_MONT,
        S_FINAL,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operands captured at acceptance so the requester may change its inputs freely.
    logic [255:0] n_r;
    logic [255:0] a_r;
    logic [255:0] b_r;

    // Transform accumulator (t < n) and Montgomery accumulator (m < 2n).
    logic [256:0] t_r;
    logic [257:0] m_r;
    logic [7:0]   cnt;

    logic         can_accept;
    logic         acc_trans;
    logic         acc_mul;
    logic         last_iter;

    logic [256:0] t_dbl;
    logic [256:0] t_nxt;
    logic [257:0] m_add_a;
    logic [257:0] m_add_n;
    logic [257:0] m_nxt;
    logic [257:0] m_red;

    // Request acceptance; transform has priority when both starts coincide.
    always_comb begin
        can_accept = (state == S_IDLE) || (state == S_DONE);
        acc_trans  = can_accept && i_start_trans;
        acc_mul    = can_accept && i_start_mul && !i_start_trans;
        last_iter  = (cnt == 8'hFF);
    end

    // One doubling-and-reduce step of the transform: t stays below n, so a
    // single conditional subtraction keeps it reduced.
    always_comb begin
        t_dbl = t_r << 1;
        if (t_dbl >= {1'b0, n_r}) begin
            t_nxt = t_dbl - {1'b0, n_r};
        end else begin
            t_nxt = t_dbl;
        end
    end

    // One radix-2 Montgomery step: add a when the scanned bit of b is set,
    // add n to make the sum even, then halve. Sums stay below 4n < 2^258.
    always_comb begin
        if (b_r[cnt]) begin
            m_add_a = m_r + {2'b00, a_r};
        end else begin
            m_add_a = m_r;
        end
        if (m_add_a[0]) begin
            m_add_n = m_add_a + {2'b00, n_r};
        end else begin
            m_add_n = m_add_a;
        end
        m_nxt = m_add_n >> 1;
        if (m_r >= {2'b00, n_r}) begin
            m_red = m_r - {2'b00, n_r};
        end else begin
            m_red = m_r;
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a start seen in S_DONE chains straight into the next job.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (acc_trans) begin
                    state_nxt = S_TRANS;
                end else if (acc_mul) begin
                    state_nxt = S_MONT;
                end
            end
            S_TRANS: begin
                if (last_iter) begin
                    state_nxt = S_DONE;
                end
            end
            S_MONT: begin
                if (last_iter) begin
                    state_nxt = S_FINAL;
                end
            end
            S_FINAL: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                if (acc_trans) begin
                    state_nxt = S_TRANS;
                end else if (acc_mul) begin
                    state_nxt = S_MONT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration, and registered results with done pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            n_r           <= '0;
            a_r           <= '0;
            b_r           <= '0;
            t_r           <= '0;
            m_r           <= '0;
            cnt           <= '0;
            o_trans_done  <= 1'b0;
            o_mul_done    <= 1'b0;
            o_transreturn <= '0;
            o_mulreturn   <= '0;
        end else begin
            o_trans_done <= 1'b0;
            o_mul_done   <= 1'b0;
            if (acc_trans || acc_mul) begin
                n_r <= i_n;
                a_r <= i_op1;
                b_r <= i_op2;
                t_r <= {1'b0, i_op1};
                m_r <= '0;
                cnt <= '0;
            end else begin
                case (state)
                    S_TRANS: begin
                        t_r <= t_nxt;
                        cnt <= cnt + 8'd1;
                        if (last_iter) begin
                            o_transreturn <= t_nxt[255:0];
                            o_trans_done  <= 1'b1;
                        end
                    end
                    S_MONT: begin
                        m_r <= m_nxt;
                        cnt <= cnt + 8'd1;
                    end
                    S_FINAL: begin
                        m_r         <= m_red;
                        o_mulreturn <= m_red[255:0];
                        o_mul_done  <= 1'b1;
                    end
                    default: begin
                        cnt <= cnt;
                    end
                endcase
            end
        end
    end

    assign o_busy = (state == S_TRANS) || (state == S_MONT) || (state == S_FINAL);

endmodule
